// File: rtl/pong_rally_engine_if.sv
// Pong rally engine bus: player/serve buttons in, LED bar, scores and status out.
//   begin_btn  serve/restart button (rising edge used)
//   play_l/r   player buttons, already synchronised (rising edge used)
//   leds       LED bar, bit i = ball position i
//   score_l/r  player scores
//   button_out one-cycle pulse per accepted return
//   serving    high while waiting for a serve
//   game_over  high once a player has won
// master drives the buttons (button logic / bench), slave is the engine.
interface pong_rally_engine_if #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned SCORE_W  = 4
);
  logic                begin_btn;
  logic                play_l;
  logic                play_r;
  logic [NUM_LEDS-1:0] leds;
  logic [SCORE_W-1:0]  score_l;
  logic [SCORE_W-1:0]  score_r;
  logic                button_out;
  logic                serving;
  logic                game_over;

  modport master (
    output begin_btn, play_l, play_r,
    input  leds, score_l, score_r, button_out, serving, game_over
  );

  modport slave (
    input  begin_btn, play_l, play_r,
    output leds, score_l, score_r, button_out, serving, game_over
  );
endinterface

// File: rtl/pong_rally_engine.sv
// Two-player LED pong engine. A one-hot ball moves along the LED bar; the player the
// ball is heading toward returns it by pressing on their end LED. Each return shortens
// the step period down to MIN_DIV. Points flash the bar, first to WIN_SCORE wins.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of pong_rally_engine_if (buttons in, LEDs/scores/status out)
module pong_rally_engine #(
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned MIN_DIV    = 2,
  parameter int unsigned SPEEDUP    = 1,
  parameter int unsigned WIN_SCORE  = 7,
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned HOLD_TICKS = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  pong_rally_engine_if.slave  bus
);

  localparam int unsigned PW   = $clog2(TICK_DIV + 1);
  localparam int unsigned PosW = $clog2(NUM_LEDS);
  localparam int unsigned HW   = $clog2(HOLD_TICKS + 1);

  localparam logic [PosW-1:0]     PosRight = PosW'(NUM_LEDS - 1);
  localparam logic [PW-1:0]       TickDiv  = PW'(TICK_DIV);
  localparam logic [PW-1:0]       MinDiv   = PW'(MIN_DIV);
  localparam logic [SCORE_W-1:0]  WinScore = SCORE_W'(WIN_SCORE);
  localparam logic [HW-1:0]       HoldLast = HW'(HOLD_TICKS - 1);
  localparam logic [NUM_LEDS-1:0] LedOne   = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LeftHalf = {NUM_LEDS{1'b1}} >> (NUM_LEDS - NUM_LEDS / 2);

  typedef enum logic [1:0] {StServe, StMove, StPoint, StOver} state_e;

  state_e              state_q, state_d;
  logic                server_q, server_d;  // 0 = left serves, 1 = right serves
  logic                dir_q, dir_d;        // 1 = moving right, 0 = moving left
  logic [PosW-1:0]     pos_q, pos_d;
  logic [PW-1:0]       period_q, period_d;
  logic [PW-1:0]       cnt_q, cnt_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [SCORE_W-1:0]  score_l_q, score_l_d;
  logic [SCORE_W-1:0]  score_r_q, score_r_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                button_q, button_d;
  logic                serving_q, game_over_q;
  logic                begin_q, play_l_q, play_r_q;

  logic begin_press, play_l_press, play_r_press;
  logic recv_press, at_end, step;

  assign begin_press  = bus.begin_btn & ~begin_q;
  assign play_l_press = bus.play_l & ~play_l_q;
  assign play_r_press = bus.play_r & ~play_r_q;

  // The receiver is whoever the ball is heading toward.
  assign recv_press = dir_q ? play_r_press : play_l_press;
  assign at_end     = (pos_q == (dir_q ? PosRight : '0));
  assign step       = (cnt_q == period_q - PW'(1));

  always_comb begin
    state_d   = state_q;
    server_d  = server_q;
    dir_d     = dir_q;
    pos_d     = pos_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    button_d  = 1'b0;

    unique case (state_q)
      StServe: begin
        if (begin_press) begin
          state_d = StMove;
          cnt_d   = '0;
        end
      end
      StMove: begin
        if (recv_press && at_end) begin
          // Return wins over a step due in the same cycle.
          dir_d    = ~dir_q;
          cnt_d    = '0;
          button_d = 1'b1;
          if (32'(period_q) >= MIN_DIV + SPEEDUP) period_d = period_q - PW'(SPEEDUP);
          else                                    period_d = MinDiv;
        end else if (recv_press || (step && at_end)) begin
          // Early press or miss: the non-receiver scores, the receiver serves next.
          state_d  = StPoint;
          cnt_d    = '0;
          hold_d   = '0;
          server_d = dir_q;
          if (dir_q) score_l_d = score_l_q + SCORE_W'(1);
          else       score_r_d = score_r_q + SCORE_W'(1);
        end else if (step) begin
          cnt_d = '0;
          pos_d = dir_q ? pos_q + PosW'(1) : pos_q - PosW'(1);
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      StPoint: begin
        // Flash lasts HOLD_TICKS step periods at the rally's final speed.
        if (step) begin
          cnt_d = '0;
          if (hold_q == HoldLast) begin
            hold_d = '0;
            if (score_l_q == WinScore || score_r_q == WinScore) begin
              state_d = StOver;
            end else begin
              state_d  = StServe;
              period_d = TickDiv;
              pos_d    = server_q ? PosRight : '0;
              dir_d    = ~server_q;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      StOver: begin
        if (begin_press) begin
          state_d   = StServe;
          score_l_d = '0;
          score_r_d = '0;
          server_d  = 1'b0;
          pos_d     = '0;
          dir_d     = 1'b1;
          period_d  = TickDiv;
          cnt_d     = '0;
        end
      end
      default: state_d = StServe;
    endcase

    // LED image is registered alongside the state it belongs to.
    unique case (state_d)
      StPoint: leds_d = '1;
      StOver:  leds_d = (score_l_d == WinScore) ? LeftHalf : ~LeftHalf;
      default: leds_d = LedOne << pos_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StServe;
      server_q    <= 1'b0;
      dir_q       <= 1'b1;
      pos_q       <= '0;
      period_q    <= TickDiv;
      cnt_q       <= '0;
      hold_q      <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      leds_q      <= LedOne;
      button_q    <= 1'b0;
      serving_q   <= 1'b1;
      game_over_q <= 1'b0;
      begin_q     <= 1'b0;
      play_l_q    <= 1'b0;
      play_r_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      server_q    <= server_d;
      dir_q       <= dir_d;
      pos_q       <= pos_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      leds_q      <= leds_d;
      button_q    <= button_d;
      serving_q   <= (state_d == StServe);
      game_over_q <= (state_d == StOver);
      begin_q     <= bus.begin_btn;
      play_l_q    <= bus.play_l;
      play_r_q    <= bus.play_r;
    end
  end

  assign bus.leds       = leds_q;
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.button_out = button_q;
  assign bus.serving    = serving_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_pong_rally_engine.sv
// Scoreboard bench for pong_rally_engine. Stimulus queues every expected change of the
// output vector together with the number of clock edges since the previous change; a
// monitor pops and compares whenever the outputs change.
module tb_pong_rally_engine;

  localparam int unsigned NL = 8;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  pong_rally_engine_if #(.NUM_LEDS(NL), .SCORE_W(SW)) bus ();

  pong_rally_engine #(
    .NUM_LEDS(NL), .TICK_DIV(4), .MIN_DIV(2), .SPEEDUP(1),
    .WIN_SCORE(3), .SCORE_W(SW), .HOLD_TICKS(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] leds;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       bo;
    logic       srv;
    logic       go;
  } snap_t;

  snap_t exp_snap[$];
  int    exp_delta[$];
  string exp_name[$];

  function automatic string fmt(input snap_t s);
    return $sformatf("leds=%h sl=%0d sr=%0d bo=%b srv=%b go=%b",
                     s.leds, s.sl, s.sr, s.bo, s.srv, s.go);
  endfunction

  // delta < 0: edge count since the previous change is not checked
  function automatic void push(input int delta, input logic [7:0] leds, input int sl,
                               input int sr, input bit bo, input bit srv, input bit go,
                               input string name);
    snap_t s;
    s.leds = leds; s.sl = 4'(sl); s.sr = 4'(sr); s.bo = bo; s.srv = srv; s.go = go;
    exp_snap.push_back(s);
    exp_delta.push_back(delta);
    exp_name.push_back(name);
  endfunction

  // Ball walk from position a to b inclusive while in MOVE.
  function automatic void push_steps(input int a, input int b, input int first_delta,
                                     input int delta, input int sl, input int sr,
                                     input string name);
    int p = a;
    int d = first_delta;
    logic [7:0] one = 8'h01;
    forever begin
      push(d, one << p, sl, sr, 1'b0, 1'b0, 1'b0, $sformatf("%s_pos%0d", name, p));
      if (p == b) break;
      p = (b > a) ? p + 1 : p - 1;
      d = delta;
    end
  endfunction

  // Monitor
  initial begin : monitor
    snap_t cur, prev, want;
    bit    have_prev = 1'b0;
    int    last = 0;
    int    wd;
    string nm;
    forever begin
      @(negedge clk);
      cur.leds = bus.leds; cur.sl = bus.score_l; cur.sr = bus.score_r;
      cur.bo = bus.button_out; cur.srv = bus.serving; cur.go = bus.game_over;
      if (!have_prev || cur != prev) begin
        if (exp_snap.size() == 0) begin
          checks++;
          $display("FAIL unexpected_change: got %s, required no change", fmt(cur));
        end else begin
          want = exp_snap.pop_front();
          wd   = exp_delta.pop_front();
          nm   = exp_name.pop_front();
          checks++;
          if (cur == want) passes++;
          else $display("FAIL %s: got %s, required %s", nm, fmt(cur), fmt(want));
          if (wd >= 0) begin
            checks++;
            if (cyc - last == wd) passes++;
            else $display("FAIL %s_delay: got %0d cycles, required %0d", nm, cyc - last, wd);
          end
        end
        prev = cur;
        have_prev = 1'b1;
        last = cyc;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0 = begin, 1 = left, 2 = right; returns just after the edge that sees the press
  task automatic pulse(input int which);
    case (which)
      0: bus.begin_btn = 1'b1;
      1: bus.play_l = 1'b1;
      default: bus.play_r = 1'b1;
    endcase
    edges(1);
    case (which)
      0: bus.begin_btn = 1'b0;
      1: bus.play_l = 1'b0;
      default: bus.play_r = 1'b0;
    endcase
  endtask

  initial begin : stimulus
    bus.begin_btn = 1'b0;
    bus.play_l = 1'b0;
    bus.play_r = 1'b0;
    push(-1, 8'h01, 0, 0, 0, 1, 0, "reset");
    edges(3);
    rst_n = 1'b1;
    edges(2);

    // Serve from left, right never presses: left scores.
    push(-1, 8'h01, 0, 0, 0, 0, 0, "serve_to_move");
    push_steps(1, 7, 4, 4, 0, 0, "step_r");
    push(4, 8'hFF, 1, 0, 0, 0, 0, "miss_point");
    push(8, 8'h80, 1, 0, 0, 1, 0, "serve_from_r");
    pulse(0);
    edges(42);

    // Rally with speed-up, coincident press/step, held button causing a miss.
    push(3, 8'h80, 1, 0, 0, 0, 0, "move_l");
    push_steps(6, 0, 4, 4, 1, 0, "step_l");
    push(2, 8'h01, 1, 0, 1, 0, 0, "return_l");
    push(1, 8'h01, 1, 0, 0, 0, 0, "return_l_end");
    push_steps(1, 7, 2, 3, 1, 0, "step_p3");
    push(3, 8'h80, 1, 0, 1, 0, 0, "return_r_on_step");
    push(1, 8'h80, 1, 0, 0, 0, 0, "return_r_end");
    push_steps(6, 0, 1, 2, 1, 0, "step_p2l");
    push(1, 8'h01, 1, 0, 1, 0, 0, "return_l_min");
    push(1, 8'h01, 1, 0, 0, 0, 0, "return_l_min_end");
    push_steps(1, 7, 1, 2, 1, 0, "step_p2r");
    push(1, 8'h80, 1, 0, 1, 0, 0, "return_r_hold");
    push(1, 8'h80, 1, 0, 0, 0, 0, "return_r_hold_end");
    push_steps(6, 0, 1, 2, 1, 0, "step_p2l2");
    push(1, 8'h01, 1, 0, 1, 0, 0, "return_l2");
    push(1, 8'h01, 1, 0, 0, 0, 0, "return_l2_end");
    push_steps(1, 7, 1, 2, 1, 0, "step_p2r2");
    push(2, 8'hFF, 2, 0, 0, 0, 0, "held_miss");
    push(4, 8'h80, 2, 0, 0, 1, 0, "serve_from_r2");
    pulse(0);
    edges(29); pulse(1);
    edges(23); pulse(2);
    edges(14); pulse(1);
    edges(5);  pulse(1);
    edges(8);  bus.play_r = 1'b1;
    edges(1);
    edges(14); pulse(1);
    edges(20); bus.play_r = 1'b0;
    edges(1);

    // Early left press at 0x10, right presses ignored: right scores.
    push(2, 8'h80, 2, 0, 0, 0, 0, "move_l3");
    push_steps(6, 4, 4, 4, 2, 0, "step_l3");
    push(2, 8'hFF, 2, 1, 0, 0, 0, "early_l");
    push(8, 8'h01, 2, 1, 0, 1, 0, "serve_from_l");
    pulse(0);
    edges(12); pulse(2); pulse(1);
    edges(9);

    // Early right press at 0x10 gives left the winning point.
    push(2, 8'h01, 2, 1, 0, 0, 0, "move_r4");
    push_steps(1, 4, 4, 4, 2, 1, "step_r4");
    push(2, 8'hFF, 3, 1, 0, 0, 0, "early_r");
    push(8, 8'h0F, 3, 1, 0, 0, 1, "game_over");
    push(2, 8'h01, 0, 0, 0, 1, 0, "restart");
    pulse(0);
    edges(16); pulse(1); pulse(2);
    edges(9);  pulse(0);

    // New game, miss, then asynchronous reset during the flash.
    push(2, 8'h01, 0, 0, 0, 0, 0, "move5");
    push_steps(1, 7, 4, 4, 0, 0, "step_r5");
    push(4, 8'hFF, 1, 0, 0, 0, 0, "miss5");
    push(2, 8'h01, 0, 0, 0, 1, 0, "async_reset");
    edges(1);
    pulse(0);
    edges(34);
    rst_n = 1'b0;
    edges(3);
    rst_n = 1'b1;
    edges(4);

    for (int i = 0; i < 20 && exp_snap.size() != 0; i++) edges(1);
    checks++;
    if (exp_snap.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expected changes, required 0", exp_snap.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pong_rally_engine.md
Name: pong_rally_engine

Overview:
Two-player LED pong engine, the parametrised successor of the single-player 8-LED Lab3 game.
- A one-hot ball travels along a NUM_LEDS-wide LED bar.
- Each player returns the ball by pressing their Play button while the ball sits on their end LED.
- Every return speeds the ball up. Scores are kept, and the block declares a winner at WIN_SCORE.
- Sits between the debounced/synchronised button logic and the LED/score display drivers.

Parameters:
NUM_LEDS, 8, LED bar width (>=3); ball positions 0 (left end) .. NUM_LEDS-1 (right end)
TICK_DIV, 4, initial clock cycles per ball step (>=2)
MIN_DIV, 2, fastest allowed cycles per step (1 <= MIN_DIV <= TICK_DIV)
SPEEDUP, 1, cycles removed from step period on each successful return
WIN_SCORE, 7, points needed to win (< 2^SCORE_W)
SCORE_W, 4, score counter width
HOLD_TICKS, 2, ball-step periods the point flash is held

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-low reset
Begin  input  1  serve/restart request; rising edge detected internally
PlayL  input  1  left player button (already synchronised); rising edge detected internally
PlayR  input  1  right player button (already synchronised); rising edge detected internally
Leds  output  NUM_LEDS  LED bar; bit i = position i
ScoreL  output  SCORE_W  left player score
ScoreR  output  SCORE_W  right player score
ButtonOut  output  1  one-cycle pulse on each accepted return
Serving  output  1  high while waiting for a serve
GameOver  output  1  high in OVER state

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=SERVE, server=left, pos=0, dir=right
  - period=TICK_DIV, tick counter=0
  - scores=0, ButtonOut=0, Serving=1, GameOver=0
  - Leds=1 (only bit 0 lit)
  - Edge-detect registers clear to 0.
- Edge detect: press = input high now and low in the previous cycle. A held button generates a single press.
- Tick: the counter increments every cycle in MOVE. When counter==period-1 it is a step: counter returns to 0 and pos moves by 1 in dir. The counter is also cleared on entry to every state.
- States:
  - SERVE:
    - Leds=one-hot(pos); ball at the server's end (left: pos 0, dir right; right: pos NUM_LEDS-1, dir left).
    - period reloads to TICK_DIV.
    - Begin press -> MOVE. Play presses are ignored.
  - MOVE:
    - Leds=one-hot(pos).
    - The receiver is the player the ball moves toward. Only the receiver's presses count; the other player's presses are ignored.
    - Receiver press while pos == receiver end (return): dir flips; pos does not change that cycle; counter=0; period=max(period-SPEEDUP, MIN_DIV); ButtonOut=1 for exactly that cycle.
    - Receiver press while pos != receiver end (early press): point to the non-receiver.
    - Step due while pos == receiver end (miss): point to the non-receiver.
    - A press and a step due in the same cycle at the end LED count as a return.
  - POINT:
    - On entry, the scorer's score increments.
    - Leds = all ones for HOLD_TICKS*period cycles, then:
      - score==WIN_SCORE -> OVER;
      - otherwise -> SERVE, with server = the player who lost the point.
  - OVER:
    - GameOver=1.
    - Leds = winner's half lit: left winner lights bits [NUM_LEDS/2-1:0], right winner lights the upper bits.
    - Begin press -> scores cleared, server=left, -> SERVE.
- Serving=1 only in SERVE. ButtonOut=0 outside return cycles.
- Width rules:
  - period and counter are clog2(TICK_DIV+1) bits; period never drops below MIN_DIV.
  - Scores never exceed WIN_SCORE.
  - pos is clog2(NUM_LEDS) bits and never wraps.
- Reset mid-rally or mid-flash: immediate return to the reset values above. No partial score update.

Test Plan:
(All tests use NUM_LEDS=8, TICK_DIV=4, MIN_DIV=2, SPEEDUP=1, WIN_SCORE=3, HOLD_TICKS=2.)
- Reset then Begin pulse -> Leds=0x01 during SERVE; then 0x02 four cycles after MOVE entry, 0x04 after 8, ..., 0x80 after 28 cycles; ButtonOut stays 0.
- No press at 0x80 -> 4 cycles later POINT: ScoreL=1, Leds=0xFF for 8 cycles. Then SERVE from right: Leds=0x80, Serving=1.
- PlayR press while Leds=0x80 -> ButtonOut high for 1 cycle; ball reverses to 0x40 after 3 cycles (period=3). After a PlayL return at 0x01, the step period is 2 and stays at 2 on further returns.
- PlayR press while Leds=0x10 moving right -> ScoreL increments; PlayL presses during the same rally have no effect.
- Hold PlayR high across the whole window -> only the first rising edge counts. A press and a step due in the same cycle -> return, not a miss.
- Left reaches 3 points -> GameOver=1, Leds=0x0F; Begin -> scores 0, Leds=0x01. Assert Rst low mid-rally -> all outputs take reset values asynchronously.
